// File: rtl/mac_to_axi_lite_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_to_axi_lite_buffer : one-frame MAC RX buffer exposed as AXI4-Lite slave
// Rev 1.0
// ----------------------------------------------------------------------------
module mac_to_axi_lite_buffer #(
  parameter int DEPTH_WORDS = 512,
  parameter int AXI_ADDR_W  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [31:0]           mac_rxd_i,
  input  logic [1:0]            mac_ben_i,
  input  logic                  mac_rxda_i,
  input  logic                  mac_rxsop_i,
  input  logic                  mac_rxeop_i,
  input  logic                  mac_rxdv_i,
  output logic                  mac_rxrqrd_o,
  input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int              c_aw        = $clog2(DEPTH_WORDS);
  localparam logic [c_aw:0]   c_depth     = (c_aw+1)'(DEPTH_WORDS);
  localparam logic [c_aw:0]   c_one       = (c_aw+1)'(1);
  localparam logic [15:0]     c_ovf_len   = 16'(4*DEPTH_WORDS);
  localparam logic [13:0]     c_data_base = 14'h0400;
  localparam logic [13:0]     c_depth_w   = 14'(DEPTH_WORDS);
  localparam logic [31:0]     c_id        = 32'h4D41_0001;
  localparam logic [1:0]      c_okay      = 2'b00;
  localparam logic [1:0]      c_slverr    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_HOLD = 2'd3
  } t_rx_state;

  t_rx_state       r_state;
  logic [c_aw:0]   r_wptr;
  logic            r_frame_ready;
  logic            r_overflow;
  logic            r_rqrd;
  logic [15:0]     r_length;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [13:0]     r_addr_w;
  logic            r_rd_pend;

  logic            w_accept;
  logic            w_room;
  logic            w_wr_en;
  logic [c_aw-1:0] w_wr_idx;
  logic [2:0]      w_bytes;
  logic [15:0]     w_len_next;
  logic            w_release;
  logic [13:0]     w_doff;
  logic [31:0]     w_rdata;
  logic [1:0]      w_rresp;

  assign mac_rxrqrd_o = r_rqrd;

  // A word is taken in REQ only when it opens a frame; in RECV every valid word counts.
  assign w_accept = mac_rxdv_i &&
                    ((r_state == S_REQ && mac_rxsop_i) || r_state == S_RECV);
  assign w_room   = (r_wptr < c_depth);
  assign w_wr_en  = ARESETN && w_accept && (mac_rxsop_i || w_room);
  assign w_wr_idx = mac_rxsop_i ? '0 : r_wptr[c_aw-1:0];
  assign w_bytes  = (mac_ben_i == 2'b00) ? 3'd4 : {1'b0, mac_ben_i};

  always_comb begin
    w_len_next = c_ovf_len;
    if (mac_rxsop_i)
      w_len_next = 16'(w_bytes);
    else if (w_room)
      w_len_next = 16'({r_wptr, 2'b00}) + 16'(w_bytes);
  end

  assign w_release = S_AXI_RVALID && S_AXI_RREADY &&
                     (r_addr_w == 14'd3) && (r_state == S_HOLD);

  always_ff @(posedge ACLK) begin
    if (w_wr_en)
      r_mem[w_wr_idx] <= mac_rxd_i;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state       <= S_IDLE;
      r_rqrd        <= 1'b0;
      r_frame_ready <= 1'b0;
      r_overflow    <= 1'b0;
      r_length      <= '0;
      r_wptr        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mac_rxda_i) begin
            r_state <= S_REQ;
            r_rqrd  <= 1'b1;
          end
        end
        S_REQ, S_RECV: begin
          if (w_accept) begin
            if (mac_rxsop_i) begin
              r_wptr     <= c_one;
              r_overflow <= 1'b0;
            end else if (w_room) begin
              r_wptr <= r_wptr + c_one;
            end else begin
              r_overflow <= 1'b1;
            end
            if (mac_rxeop_i) begin
              r_length      <= w_len_next;
              r_frame_ready <= 1'b1;
              r_rqrd        <= 1'b0;
              r_state       <= S_HOLD;
            end else begin
              r_state <= S_RECV;
            end
          end
        end
        S_HOLD: begin
          if (w_release) begin
            r_frame_ready <= 1'b0;
            r_overflow    <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_doff = r_addr_w - c_data_base;

  always_comb begin
    w_rdata = '0;
    w_rresp = c_slverr;
    if (r_addr_w >= c_data_base && w_doff < c_depth_w) begin
      w_rdata = r_mem[w_doff[c_aw-1:0]];
      w_rresp = c_okay;
    end else begin
      case (r_addr_w)
        14'd0: begin w_rdata = {30'b0, r_overflow, r_frame_ready}; w_rresp = c_okay; end
        14'd1: begin w_rdata = {16'b0, r_length};                  w_rresp = c_okay; end
        14'd2: begin w_rdata = c_id;                               w_rresp = c_okay; end
        14'd3: begin w_rdata = '0;                                 w_rresp = c_okay; end
        default: ;
      endcase
    end
  end

  // Address capture -> registered lookup -> hold R until accepted; one read in flight.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
      r_rd_pend     <= 1'b0;
      r_addr_w      <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      r_addr_w      <= S_AXI_ARADDR[15:2];
      S_AXI_ARREADY <= 1'b0;
      r_rd_pend     <= 1'b1;
    end else if (r_rd_pend) begin
      r_rd_pend    <= 1'b0;
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= w_rdata;
      S_AXI_RRESP  <= w_rresp;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end else if (!S_AXI_RVALID) begin
      S_AXI_ARREADY <= 1'b1;
    end
  end

  logic w_unused;
  assign w_unused = ^{S_AXI_ARADDR[1:0], w_doff};

  generate
    if (AXI_ADDR_W > 16) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^S_AXI_ARADDR[AXI_ADDR_W-1:16];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_to_axi_lite_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mac_to_axi_lite_buffer : randomized bench with a frame-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mac_to_axi_lite_buffer;

  localparam int DEPTH = 512;
  localparam int AW    = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [31:0]   mac_rxd_i = '0;
  logic [1:0]    mac_ben_i = '0;
  logic          mac_rxda_i = 1'b0;
  logic          mac_rxsop_i = 1'b0;
  logic          mac_rxeop_i = 1'b0;
  logic          mac_rxdv_i = 1'b0;
  logic          mac_rxrqrd_o;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b0;

  mac_to_axi_lite_buffer #(.DEPTH_WORDS(DEPTH), .AXI_ADDR_W(AW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .mac_rxd_i(mac_rxd_i), .mac_ben_i(mac_ben_i), .mac_rxda_i(mac_rxda_i),
    .mac_rxsop_i(mac_rxsop_i), .mac_rxeop_i(mac_rxeop_i), .mac_rxdv_i(mac_rxdv_i),
    .mac_rxrqrd_o(mac_rxrqrd_o),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  // Frame-level reference: what software should see after the last completed frame.
  logic [31:0] ref_mem [DEPTH];
  logic [15:0] ref_len = '0;
  logic        ref_ready = 1'b0;
  logic        ref_ovf = 1'b0;
  logic [31:0] frame_q[$];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_capture(input logic [1:0] ben);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n && i < DEPTH; i++) ref_mem[i] = frame_q[i];
    ref_ovf   = (n > DEPTH);
    ref_len   = ref_ovf ? 16'(4*DEPTH) : 16'(4*(n-1) + ((ben == 2'b00) ? 4 : int'(ben)));
    ref_ready = 1'b1;
  endtask

  task automatic mac_word(input logic [31:0] d, input logic sop, input logic eop,
                          input logic [1:0] ben);
    mac_rxd_i = d; mac_rxsop_i = sop; mac_rxeop_i = eop; mac_ben_i = ben; mac_rxdv_i = 1'b1;
    tick();
    mac_rxdv_i = 1'b0; mac_rxsop_i = 1'b0; mac_rxeop_i = 1'b0;
  endtask

  task automatic arm();
    mac_rxda_i = 1'b1;
    tick();
    mac_rxda_i = 1'b0;
    checks++;
    if (mac_rxrqrd_o !== 1'b1) begin
      errors++; $display("FAIL rqrd_assert: got %b want 1", mac_rxrqrd_o);
    end
  endtask

  task automatic send_queue(input logic [1:0] ben, input bit gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      mac_word(frame_q[i], i == 0, i == frame_q.size() - 1, ben);
      if (i == frame_q.size() - 1) begin
        checks++;
        if (mac_rxrqrd_o !== 1'b0) begin
          errors++; $display("FAIL rqrd_after_eop: got %b want 0", mac_rxrqrd_o);
        end
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        tick();
      end
    end
    model_capture(ben);
  endtask

  task automatic send_frame(input int n, input logic [1:0] ben, input bit gaps);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back($urandom);
    send_queue(ben, gaps);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int stall,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output logic stable);
    int n;
    logic [31:0] d0;
    logic [1:0]  r0;
    n = 0;
    while (S_AXI_ARREADY !== 1'b1 && n < 10) begin tick(); n++; end
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    lat = 1;
    while (S_AXI_RVALID !== 1'b1 && lat < 10) begin tick(); lat++; end
    stable = 1'b1;
    if (S_AXI_RVALID !== 1'b1) begin
      checks++; errors++;
      $display("FAIL axi_timeout: addr=%h rvalid=%b want 1", addr, S_AXI_RVALID);
      data = 'x; resp = 'x;
      return;
    end
    d0 = S_AXI_RDATA; r0 = S_AXI_RRESP;
    repeat (stall) begin
      tick();
      if (S_AXI_RDATA !== d0 || S_AXI_RRESP !== r0 || S_AXI_RVALID !== 1'b1) stable = 1'b0;
    end
    S_AXI_RREADY = 1'b1;
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    ARESETN = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if ({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, mac_rxrqrd_o} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs: got arready=%b rvalid=%b rdata=%h rresp=%b rqrd=%b want all 0",
                 S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, mac_rxrqrd_o);
      end
    end
    ARESETN = 1'b1;
    tick();
    checks++;
    if (S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL arready_after_reset: got %b want 1", S_AXI_ARREADY);
    end
    ref_ready = 1'b0; ref_ovf = 1'b0; ref_len = '0;
    axi_read(32'h0, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_status: got %h/%b want 00000000/00", d, r);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    arm();
    frame_q.delete();
    frame_q.push_back(32'h1111_1111);
    frame_q.push_back(32'h2222_2222);
    frame_q.push_back(32'h3333_3333);
    send_queue(2'b10, 1'b0);
    axi_read(32'h0, 0, d, r, lat, st);
    checks++;
    if (d !== {30'b0, ref_ovf, ref_ready} || r !== 2'b00) begin
      errors++; $display("FAIL single_status: got %h/%b want %h/00", d, r, {30'b0, ref_ovf, ref_ready});
    end
    axi_read(32'h4, 0, d, r, lat, st);
    checks++;
    if (d !== {16'b0, ref_len} || r !== 2'b00) begin
      errors++; $display("FAIL single_length: got %h/%b want %h/00", d, r, {16'b0, ref_len});
    end
    for (int i = 0; i < 3; i++) begin
      axi_read(32'h1000 + 32'(4*i), 0, d, r, lat, st);
      checks++;
      if (d !== ref_mem[i] || r !== 2'b00) begin
        errors++; $display("FAIL single_data[%0d]: got %h/%b want %h/00", i, d, r, ref_mem[i]);
      end
    end
  endtask

  task automatic test_axi_timing();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    axi_read(32'h4, 3, d, r, lat, st);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL rvalid_latency: got %0d want 2", lat);
    end
    checks++;
    if (st !== 1'b1) begin
      errors++; $display("FAIL r_stable_under_stall: got %b want 1", st);
    end
    checks++;
    if (d !== {16'b0, ref_len} || r !== 2'b00) begin
      errors++; $display("FAIL timing_length: got %h/%b want %h/00", d, r, {16'b0, ref_len});
    end
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL after_r_handshake: got rvalid=%b arready=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic do_release(input string tag);
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    axi_read(32'hC, $urandom_range(0, 2), d, r, lat, st);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL %s_release_resp: got %h/%b want 00000000/00", tag, d, r);
    end
    ref_ready = 1'b0; ref_ovf = 1'b0;
    axi_read(32'h0, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL %s_status_after_release: got %h want 00000000", tag, d);
    end
  endtask

  task automatic test_release_rearm();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    do_release("rearm");
    arm();
    frame_q.delete();
    frame_q.push_back($urandom);
    send_queue(2'b00, 1'b0);
    axi_read(32'h4, 0, d, r, lat, st);
    checks++;
    if (d !== {16'b0, ref_len}) begin
      errors++; $display("FAIL rearm_length: got %h want %h", d, {16'b0, ref_len});
    end
    axi_read(32'h1000, 0, d, r, lat, st);
    checks++;
    if (d !== ref_mem[0]) begin
      errors++; $display("FAIL rearm_data0: got %h want %h", d, ref_mem[0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    logic [31:0] bad [2];
    bad[0] = 32'h10;
    bad[1] = 32'h1000 + 32'(4*DEPTH);
    for (int i = 0; i < 2; i++) begin
      axi_read(bad[i], 0, d, r, lat, st);
      checks++;
      if (d !== 32'h0 || r !== 2'b10) begin
        errors++; $display("FAIL slverr[%h]: got %h/%b want 00000000/10", bad[i], d, r);
      end
    end
    axi_read(32'h2, 0, d, r, lat, st);
    checks++;
    if (d !== {30'b0, ref_ovf, ref_ready} || r !== 2'b00) begin
      errors++; $display("FAIL low_bits_ignored: got %h/%b want %h/00", d, r, {30'b0, ref_ovf, ref_ready});
    end
    axi_read(32'h8, 0, d, r, lat, st);
    checks++;
    if (d !== 32'h4D41_0001 || r !== 2'b00) begin
      errors++; $display("FAIL id_reg: got %h/%b want 4d410001/00", d, r);
    end
    // MAC traffic while a frame is held must not disturb it
    mac_rxda_i = 1'b1;
    mac_word($urandom, 1'b1, 1'b1, 2'b01);
    mac_word($urandom, 1'b1, 1'b0, 2'b01);
    mac_rxda_i = 1'b0;
    checks++;
    if (mac_rxrqrd_o !== 1'b0) begin
      errors++; $display("FAIL hold_rqrd: got %b want 0", mac_rxrqrd_o);
    end
    axi_read(32'h1000, 0, d, r, lat, st);
    checks++;
    if (d !== ref_mem[0]) begin
      errors++; $display("FAIL hold_data0: got %h want %h", d, ref_mem[0]);
    end
    axi_read(32'h4, 0, d, r, lat, st);
    checks++;
    if (d !== {16'b0, ref_len}) begin
      errors++; $display("FAIL hold_length: got %h want %h", d, {16'b0, ref_len});
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    do_release("ovf_pre");
    arm();
    send_frame(DEPTH + 3, 2'b00, 1'b0);
    axi_read(32'h0, 0, d, r, lat, st);
    checks++;
    if (d !== {30'b0, ref_ovf, ref_ready} || d !== 32'h3) begin
      errors++; $display("FAIL ovf_status: got %h want 00000003", d);
    end
    axi_read(32'h4, 0, d, r, lat, st);
    checks++;
    if (d !== {16'b0, ref_len}) begin
      errors++; $display("FAIL ovf_length: got %h want %h", d, {16'b0, ref_len});
    end
    axi_read(32'h1000 + 32'(4*(DEPTH-1)), 1, d, r, lat, st);
    checks++;
    if (d !== ref_mem[DEPTH-1] || r !== 2'b00) begin
      errors++; $display("FAIL ovf_last_word: got %h/%b want %h/00", d, r, ref_mem[DEPTH-1]);
    end
    do_release("ovf");
  endtask

  task automatic test_restart();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    arm();
    for (int i = 0; i < 5; i++) mac_word($urandom, i == 0, 1'b0, 2'b00);
    frame_q.delete();
    frame_q.push_back($urandom);
    frame_q.push_back($urandom);
    send_queue(2'b00, 1'b0);
    axi_read(32'h4, 0, d, r, lat, st);
    checks++;
    if (d !== {16'b0, ref_len} || ref_len !== 16'd8) begin
      errors++; $display("FAIL restart_length: got %h want 00000008", d);
    end
    for (int i = 0; i < 2; i++) begin
      axi_read(32'h1000 + 32'(4*i), 0, d, r, lat, st);
      checks++;
      if (d !== ref_mem[i]) begin
        errors++; $display("FAIL restart_data[%0d]: got %h want %h", i, d, ref_mem[i]);
      end
    end
    do_release("restart");
  endtask

  task automatic test_random();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    int n, idx;
    logic [1:0] ben;
    for (int f = 0; f < 4; f++) begin
      arm();
      mac_word($urandom, 1'b0, 1'b0, 2'b00);
      n   = $urandom_range(1, 24);
      ben = 2'($urandom_range(0, 3));
      send_frame(n, ben, 1'b1);
      axi_read(32'h0, $urandom_range(0, 2), d, r, lat, st);
      checks++;
      if (d !== {30'b0, ref_ovf, ref_ready}) begin
        errors++; $display("FAIL rand%0d_status: got %h want %h", f, d, {30'b0, ref_ovf, ref_ready});
      end
      axi_read(32'h4, $urandom_range(0, 2), d, r, lat, st);
      checks++;
      if (d !== {16'b0, ref_len}) begin
        errors++; $display("FAIL rand%0d_length: got %h want %h", f, d, {16'b0, ref_len});
      end
      repeat (2) begin
        idx = $urandom_range(0, n - 1);
        axi_read(32'h1000 + 32'(4*idx), $urandom_range(0, 2), d, r, lat, st);
        checks++;
        if (d !== ref_mem[idx] || r !== 2'b00 || st !== 1'b1) begin
          errors++; $display("FAIL rand%0d_data[%0d]: got %h/%b stable=%b want %h/00 stable=1",
                             f, idx, d, r, st, ref_mem[idx]);
        end
      end
      do_release("rand");
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic [1:0] r; int lat; logic st;
    arm();
    mac_word($urandom, 1'b1, 1'b0, 2'b00);
    mac_word($urandom, 1'b0, 1'b0, 2'b00);
    ARESETN = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
    ref_ready = 1'b0; ref_ovf = 1'b0; ref_len = '0;
    checks++;
    if (mac_rxrqrd_o !== 1'b0) begin
      errors++; $display("FAIL midreset_rqrd: got %b want 0", mac_rxrqrd_o);
    end
    axi_read(32'h4, 0, d, r, lat, st);
    checks++;
    if (d !== {16'b0, ref_len}) begin
      errors++; $display("FAIL midreset_length: got %h want %h", d, {16'b0, ref_len});
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_axi_timing();
    test_release_rearm();
    test_errors();
    test_overflow();
    test_restart();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
